// File: rtl/galvo_pkg.sv
// galvo_pkg
// Shared definitions for the galvo DAC writer: the controller state enum,
// the DAC word and code widths, the default command nibbles for the X and
// Y words, and a helper that assembles one 16-bit DAC word.
package galvo_pkg;

   localparam int WORD_W = 16;                 // bits per DAC frame
   localparam int CODE_W = 12;                 // galvo code width
   localparam int CMD_W  = WORD_W - CODE_W;    // command nibble width

   // Channel A / channel B, unbuffered, 1x gain, active.
   localparam logic [CMD_W-1:0] CFG_X_DEFAULT = 4'b0011;
   localparam logic [CMD_W-1:0] CFG_Y_DEFAULT = 4'b1011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT_X,
      ST_GAP,
      ST_SHIFT_Y,
      ST_LATCH
   } state_e;

   // Command nibble goes out first, then the code, MSB first.
   function automatic logic [WORD_W-1:0] dac_word(input logic [CMD_W-1:0]  cmd,
                                                  input logic [CODE_W-1:0] code);
      return {cmd, code};
   endfunction

endpackage

// File: rtl/spi_word_tx.sv
// spi_word_tx
// Shifts one 16-bit word out MSB first with a divided serial clock.
// Each bit is CLK_DIV cycles with sclk low followed by CLK_DIV cycles with
// sclk high; data only moves while sclk is low, so it is stable across
// every rising edge. A full word takes 32*CLK_DIV cycles after start.
//
// Ports
//   clk      system clock (rising edge)
//   reset    synchronous, active-high; aborts any word in flight
//   start_i  one-cycle pulse: load word_i and begin shifting
//   word_i   word to send, sampled on start_i
//   sclk_o   serial clock, idle low (registered)
//   sdi_o    serial data, MSB first (registered)
//   done_o   high during the final cycle of bit 0's high phase
module spi_word_tx
   import galvo_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [WORD_W-1:0] word_i,
   output logic              sclk_o,
   output logic              sdi_o,
   output logic              done_o
);

   localparam int              BIT_W    = $clog2(WORD_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);

   logic              active_q;
   logic              sclk_q;
   logic [WORD_W-1:0] shift_q;
   logic [BIT_W-1:0]  bit_q;
   logic [7:0]        div_q;
   logic              phase_end;

   assign phase_end = (div_q == DIV_LAST);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         shift_q  <= '0;
         bit_q    <= '0;
         div_q    <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         sclk_q   <= 1'b0;
         shift_q  <= word_i;
         bit_q    <= '0;
         div_q    <= '0;
      end else if (active_q) begin
         if (!phase_end) begin
            div_q <= div_q + 8'd1;
         end else begin
            div_q <= '0;
            if (!sclk_q) begin
               sclk_q <= 1'b1;
            end else begin
               // Falling edge of sclk: the only place the data bit advances.
               sclk_q <= 1'b0;
               if (bit_q == BIT_LAST) begin
                  active_q <= 1'b0;
               end else begin
                  bit_q   <= bit_q + BIT_W'(1);
                  shift_q <= {shift_q[WORD_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign sclk_o = sclk_q;
   assign sdi_o  = shift_q[WORD_W-1];
   assign done_o = active_q && sclk_q && phase_end && (bit_q == BIT_LAST);

endmodule

// File: rtl/galvo_dac_writer.sv
// galvo_dac_writer
// On each update strobe, takes one (x, y, laser) point and writes it to a
// dual-channel SPI DAC as two 16-bit frames ({CFG_X, x} then {CFG_Y, y}),
// then pulses LDAC so both galvo axes move together and applies the laser
// bit at the same moment. Strobes with no point or during a transfer set
// sticky underrun / overrun flags.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   strobe_in               one-cycle update tick
//   point_valid/_x/_y/_laser  offered point
//   point_ready             one-cycle accept pulse
//   dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n   DAC serial interface
//   laser_out               laser modulation
//   busy                    high from LOAD through LATCH
//   underrun, overrun       sticky error flags
module galvo_dac_writer
   import galvo_pkg::*;
#(
   parameter int               CLK_DIV = 2,
   parameter logic [CMD_W-1:0] CFG_X   = CFG_X_DEFAULT,
   parameter logic [CMD_W-1:0] CFG_Y   = CFG_Y_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              strobe_in,
   input  logic              point_valid,
   input  logic [CODE_W-1:0] point_x,
   input  logic [CODE_W-1:0] point_y,
   input  logic              point_laser,
   output logic              point_ready,
   output logic              dac_cs_n,
   output logic              dac_sclk,
   output logic              dac_sdi,
   output logic              dac_ldac_n,
   output logic              laser_out,
   output logic              busy,
   output logic              underrun,
   output logic              overrun
);

   localparam logic [8:0] GAP_LAST   = 9'(CLK_DIV - 1);
   localparam logic [8:0] LATCH_LAST = 9'(2 * CLK_DIV - 1);

   state_e            state_q;
   logic              cs_n_q;
   logic              ldac_n_q;
   logic              laser_q;
   logic              ready_q;
   logic              busy_q;
   logic              underrun_q;
   logic              overrun_q;
   logic [8:0]        cnt_q;
   logic [CODE_W-1:0] x_q;
   logic [CODE_W-1:0] y_q;
   logic              laser_cap_q;

   logic              accept;
   logic              spi_start;
   logic              spi_done;
   logic [WORD_W-1:0] spi_word_d;

   assign accept = (state_q == ST_IDLE) && strobe_in && point_valid;

   // The shifter is started from LOAD with the X word and from the last
   // GAP cycle with the Y word.
   // NOTE: every signal gets a default before the case so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      spi_start  = 1'b0;
      spi_word_d = dac_word(CFG_Y, y_q);
      case (state_q)
         ST_LOAD: begin
            spi_start  = 1'b1;
            spi_word_d = dac_word(CFG_X, x_q);
         end
         ST_GAP:  spi_start = (cnt_q == GAP_LAST);
         default: ;
      endcase
   end

   // NOTE: the point capture registers carry no reset; they are always
   // written on accept before anything reads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_q         <= point_x;
         y_q         <= point_y;
         laser_cap_q <= point_laser;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cs_n_q     <= 1'b1;
         ldac_n_q   <= 1'b1;
         laser_q    <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ready_q <= 1'b0;
         // busy_q is still high on the edge where LATCH ends, so a strobe
         // landing on that edge is an overrun, not a new point.
         if (strobe_in && busy_q) overrun_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               if (strobe_in) begin
                  if (point_valid) begin
                     ready_q <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= ST_LOAD;
                  end else begin
                     underrun_q <= 1'b1;
                     laser_q    <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               cs_n_q  <= 1'b0;
               state_q <= ST_SHIFT_X;
            end
            ST_SHIFT_X: begin
               if (spi_done) begin
                  cs_n_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cs_n_q  <= 1'b0;
                  state_q <= ST_SHIFT_Y;
               end else begin
                  cnt_q <= cnt_q + 9'd1;
               end
            end
            ST_SHIFT_Y: begin
               if (spi_done) begin
                  cs_n_q   <= 1'b1;
                  ldac_n_q <= 1'b0;
                  laser_q  <= laser_cap_q;
                  cnt_q    <= '0;
                  state_q  <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               if (cnt_q == LATCH_LAST) begin
                  ldac_n_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 9'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   spi_word_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_spi (
      .clk     (clk),
      .reset   (reset),
      .start_i (spi_start),
      .word_i  (spi_word_d),
      .sclk_o  (dac_sclk),
      .sdi_o   (dac_sdi),
      .done_o  (spi_done)
   );

   assign point_ready = ready_q;
   assign dac_cs_n    = cs_n_q;
   assign dac_ldac_n  = ldac_n_q;
   assign laser_out   = laser_q;
   assign busy        = busy_q;
   assign underrun    = underrun_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_galvo_dac_writer.sv
// tb_galvo_dac_writer
// Two instances: dut at CLK_DIV=2 and dut1 at CLK_DIV=1. Stimulus pushes
// the expected DAC frames of every accepted point into a per-instance
// queue; an independent monitor decodes the SPI pins and pops on each
// LDAC pulse.
module tb_galvo_dac_writer;

   localparam logic [3:0] CMD_X = 4'b0011;
   localparam logic [3:0] CMD_Y = 4'b1011;

   typedef struct packed {
      logic [15:0] wx;
      logic [15:0] wy;
      logic        laser;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        strobe [2];
   logic        valid  [2];
   logic [11:0] px     [2];
   logic [11:0] py     [2];
   logic        las_in [2];
   logic        ready  [2];
   logic        cs_n   [2];
   logic        sclk   [2];
   logic        sdi    [2];
   logic        ldac_n [2];
   logic        laser_o[2];
   logic        busy   [2];
   logic        under  [2];
   logic        over   [2];

   galvo_dac_writer #(.CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .strobe_in(strobe[0]), .point_valid(valid[0]),
      .point_x(px[0]), .point_y(py[0]), .point_laser(las_in[0]),
      .point_ready(ready[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
      .dac_sdi(sdi[0]), .dac_ldac_n(ldac_n[0]), .laser_out(laser_o[0]),
      .busy(busy[0]), .underrun(under[0]), .overrun(over[0])
   );

   galvo_dac_writer #(.CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .strobe_in(strobe[1]), .point_valid(valid[1]),
      .point_x(px[1]), .point_y(py[1]), .point_laser(las_in[1]),
      .point_ready(ready[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
      .dac_sdi(sdi[1]), .dac_ldac_n(ldac_n[1]), .laser_out(laser_o[1]),
      .busy(busy[1]), .underrun(under[1]), .overrun(over[1])
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic rst_seen = 1'b1;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   // Reference model state.
   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   busy_until[2];
   bit   m_under[2];
   bit   m_over[2];
   int   n_acc[2] = '{0, 0};
   int   n_rdy[2] = '{0, 0};
   int   last_acc[2];

   // Monitor state.
   logic        p_sclk[2], p_cs[2], p_ldac[2], p_busy[2], p_sdi[2];
   logic [15:0] m_sh[2];
   logic [15:0] m_w[2][2];
   logic        m_las[2];
   int          m_bits[2], m_words[2], m_ldac_cnt[2], m_busy_cnt[2];
   int          m_cs_falls[2] = '{0, 0};

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // LOAD + two 16-bit frames + gap + latch.
   function automatic int busy_len(input int i);
      int d;
      d = div_of(i);
      return 1 + 2 * (16 * 2 * d) + d + 2 * d;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Called just after a negedge; the strobe is sampled on the next edge.
   task automatic drive(input int i, input logic v, input logic [11:0] x,
                        input logic [11:0] y, input logic l);
      int   j;
      bit   und;
      exp_t e;
      j   = cyc + 1;
      und = 1'b0;
      strobe[i] = 1'b1;
      valid[i]  = v;
      px[i]     = x;
      py[i]     = y;
      las_in[i] = l;
      if (j <= busy_until[i]) begin
         m_over[i] = 1'b1;
      end else if (v) begin
         e.wx    = {CMD_X, x};
         e.wy    = {CMD_Y, y};
         e.laser = l;
         if (i == 0) exp_q0.push_back(e);
         else        exp_q1.push_back(e);
         busy_until[i] = j + busy_len(i);
         last_acc[i]   = j;
         n_acc[i]++;
      end else begin
         m_under[i] = 1'b1;
         und        = 1'b1;
      end
      @(negedge clk);
      strobe[i] = 1'b0;
      if (und) begin
         check("laser_off_after_underrun", 32'(laser_o[i]), 32'd0);
         check("underrun_set", 32'(under[i]), 32'd1);
      end
   endtask

   task automatic apply_reset(input bit chk);
      reset = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      for (int i = 0; i < 2; i++) begin
         busy_until[i] = 0;
         m_under[i]    = 1'b0;
         m_over[i]     = 1'b0;
         strobe[i]     = 1'b0;
      end
      @(negedge clk);
      if (chk) begin
         check("rst_cs_n",   32'(cs_n[0]),    32'd1);
         check("rst_sclk",   32'(sclk[0]),    32'd0);
         check("rst_sdi",    32'(sdi[0]),     32'd0);
         check("rst_ldac_n", 32'(ldac_n[0]),  32'd1);
         check("rst_laser",  32'(laser_o[0]), 32'd0);
         check("rst_ready",  32'(ready[0]),   32'd0);
         check("rst_busy",   32'(busy[0]),    32'd0);
         check("rst_under",  32'(under[0]),   32'd0);
         check("rst_over",   32'(over[0]),    32'd0);
      end
      reset = 1'b0;
   endtask

   task automatic drain(input int i);
      int t;
      t = 0;
      while ((qsize(i) != 0 || busy[i] !== 1'b0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_in_time", 32'(t < 2000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_flags(input int i);
      check("underrun_flag", 32'(under[i]), 32'(m_under[i]));
      check("overrun_flag",  32'(over[i]),  32'(m_over[i]));
      check("ready_count",   n_rdy[i],      n_acc[i]);
   endtask

   task automatic mon(input int i);
      exp_t e;
      int   qs;
      if (rst_seen) begin
         m_bits[i]     = 0;
         m_words[i]    = 0;
         m_ldac_cnt[i] = 0;
         m_busy_cnt[i] = 0;
      end else begin
         if (ready[i] === 1'b1) n_rdy[i]++;
         if (cs_n[i] === 1'b0 && p_cs[i] === 1'b1) m_cs_falls[i]++;
         if (cs_n[i] === 1'b0 && sclk[i] === 1'b1 && p_sclk[i] === 1'b0) begin
            check("sdi_stable_at_rise", 32'(sdi[i]), 32'(p_sdi[i]));
            m_sh[i] = {m_sh[i][14:0], sdi[i]};
            m_bits[i]++;
         end
         if (cs_n[i] === 1'b1 && p_cs[i] === 1'b0) begin
            check("bits_per_word", m_bits[i], 32'd16);
            check("sclk_low_at_cs_rise", 32'(sclk[i]), 32'd0);
            if (m_words[i] < 2) m_w[i][m_words[i]] = m_sh[i];
            m_words[i]++;
            m_bits[i] = 0;
         end
         if (ldac_n[i] === 1'b0) m_ldac_cnt[i]++;
         if (ldac_n[i] === 1'b0 && p_ldac[i] === 1'b1) m_las[i] = laser_o[i];
         if (ldac_n[i] === 1'b1 && p_ldac[i] === 1'b0) begin
            qs = qsize(i);
            check("point_pending_at_latch", 32'(qs != 0), 32'd1);
            if (qs != 0) begin
               e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check("words_per_point", m_words[i], 32'd2);
               check("x_word", 32'(m_w[i][0]), 32'(e.wx));
               check("y_word", 32'(m_w[i][1]), 32'(e.wy));
               check("ldac_low_cycles", m_ldac_cnt[i], 2 * div_of(i));
               check("laser_at_latch", 32'(m_las[i]), 32'(e.laser));
            end
            m_words[i]    = 0;
            m_ldac_cnt[i] = 0;
         end
         if (busy[i] === 1'b1) m_busy_cnt[i]++;
         if (busy[i] === 1'b0 && p_busy[i] === 1'b1) begin
            check("busy_cycles", m_busy_cnt[i], busy_len(i));
            m_busy_cnt[i] = 0;
         end
      end
      p_sclk[i] = sclk[i];
      p_cs[i]   = cs_n[i];
      p_ldac[i] = ldac_n[i];
      p_busy[i] = busy[i];
      p_sdi[i]  = sdi[i];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon(0);
         mon(1);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int falls0;
      for (int i = 0; i < 2; i++) begin
         strobe[i] = 1'b0; valid[i] = 1'b0; px[i] = '0; py[i] = '0; las_in[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      apply_reset(1'b1);

      // Reference point at CLK_DIV=2.
      drive(0, 1'b1, 12'hABC, 12'h123, 1'b1);
      drain(0);
      check_flags(0);
      check("laser_held_after_latch", 32'(laser_o[0]), 32'd1);

      // Strobe with no point: underrun, laser off, no chip-select activity.
      falls0 = m_cs_falls[0];
      drive(0, 1'b0, 12'h000, 12'h000, 1'b0);
      repeat (20) @(negedge clk);
      check("no_cs_on_underrun", m_cs_falls[0], falls0);
      check_flags(0);

      // Second strobe 50 cycles into a transfer.
      apply_reset(1'b0);
      drive(0, 1'b1, 12'h5A5, 12'hA5A, 1'b0);
      repeat (49) @(negedge clk);
      drive(0, 1'b1, 12'h111, 12'h222, 1'b1);
      drain(0);
      check_flags(0);

      // Strobe on the edge busy falls is an overrun; the next cycle is accepted.
      apply_reset(1'b0);
      drive(0, 1'b1, 12'h0F0, 12'hF0F, 1'b1);
      while (cyc + 1 < last_acc[0] + busy_len(0)) @(negedge clk);
      drive(0, 1'b1, 12'h333, 12'h444, 1'b0);
      drive(0, 1'b1, 12'h789, 12'h456, 1'b0);
      drain(0);
      check_flags(0);

      // Steady stream, one point every 200 cycles.
      apply_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b1, 12'($urandom), 12'($urandom), 1'($urandom));
         repeat (199) @(negedge clk);
      end
      drain(0);
      check_flags(0);

      // Randomised strobe spacing and point availability.
      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 150)) @(negedge clk);
         drive(0, 1'($urandom_range(0, 7) != 0), 12'($urandom), 12'($urandom), 1'($urandom));
      end
      drain(0);
      check_flags(0);

      // Reset in the middle of the Y frame: point is dropped, no LDAC pulse.
      apply_reset(1'b0);
      drive(0, 1'b1, 12'hC3C, 12'h3C3, 1'b1);
      while (cyc + 1 < last_acc[0] + 1 + 33 * div_of(0) + 10) @(negedge clk);
      check("cs_low_in_shift_y", 32'(cs_n[0]), 32'd0);
      apply_reset(1'b1);
      repeat (300) @(negedge clk);
      check("no_latch_after_abort", 32'(ldac_n[0]), 32'd1);
      check_flags(0);

      // CLK_DIV=1 instance: full-scale X, zero Y.
      drive(1, 1'b1, 12'hFFF, 12'h000, 1'b1);
      drain(1);
      drive(1, 1'b1, 12'($urandom), 12'($urandom), 1'b0);
      drain(1);
      check_flags(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
